// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB/CMP, bit-serial MUL (shift-add) and
// restoring DIV, under a start/busy/done handshake.
module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  div_by_zero,
  output logic                  illegal_op
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t        state_r, state_next_s;
  logic [2:0]    op_r, op_next_s;
  logic [W-1:0]  acc_r, acc_next_s;
  logic [W-1:0]  x_r, x_next_s;
  logic [W-1:0]  y_r, y_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic [W-1:0]  out_r, out_next_s;
  logic          busy_r, busy_next_s;
  logic          done_r, done_next_s;
  logic          dbz_r, dbz_next_s;
  logic          ill_r, ill_next_s;

  // MUL: acc accumulates, x is the shifting multiplicand, y the shifting multiplier.
  // DIV: acc is the partial remainder, x shifts dividend out / quotient in, y is the divisor.
  logic [W-1:0] mul_acc_s;
  logic [W:0]   div_shift_s;
  logic [W:0]   div_diff_s;
  logic         div_ge_s;
  logic [W-1:0] div_rem_s;
  logic [W-1:0] div_quo_s;

  assign mul_acc_s   = y_r[0] ? (acc_r + x_r) : acc_r;
  assign div_shift_s = {acc_r, x_r[W-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, y_r});
  assign div_diff_s  = div_shift_s - {1'b0, y_r};
  assign div_rem_s   = div_ge_s ? div_diff_s[W-1:0] : div_shift_s[W-1:0];
  assign div_quo_s   = {x_r[W-2:0], div_ge_s};

  // True magnitude comparison, not the sign of the wrapped difference
  logic           cmp_lt_s, cmp_gt_s, cmp_eq_s;
  logic [W+2:0]   cmp_wide_s;

  assign cmp_lt_s   = SIGNED_CMP ? ($signed(rs) < $signed(rt)) : (rs < rt);
  assign cmp_gt_s   = SIGNED_CMP ? ($signed(rs) > $signed(rt)) : (rs > rt);
  assign cmp_eq_s   = (rs == rt);
  assign cmp_wide_s = {{W{1'b0}}, cmp_gt_s, cmp_eq_s, cmp_lt_s};

  // Next-state and next-output logic
  always_comb begin
    state_next_s = state_r;
    op_next_s    = op_r;
    acc_next_s   = acc_r;
    x_next_s     = x_r;
    y_next_s     = y_r;
    cnt_next_s   = cnt_r;
    out_next_s   = out_r;
    busy_next_s  = 1'b0;
    done_next_s  = 1'b0;
    dbz_next_s   = dbz_r;
    ill_next_s   = ill_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_next_s = op;
          case (op)
            OP_ADD: begin
              out_next_s   = rs + rt;
              done_next_s  = 1'b1;
              dbz_next_s   = 1'b0;
              ill_next_s   = 1'b0;
              state_next_s = ST_DONE;
            end
            OP_SUB: begin
              out_next_s   = rs - rt;
              done_next_s  = 1'b1;
              dbz_next_s   = 1'b0;
              ill_next_s   = 1'b0;
              state_next_s = ST_DONE;
            end
            OP_CMP: begin
              out_next_s   = cmp_wide_s[W-1:0];
              done_next_s  = 1'b1;
              dbz_next_s   = 1'b0;
              ill_next_s   = 1'b0;
              state_next_s = ST_DONE;
            end
            OP_MUL, OP_DIV: begin
              acc_next_s   = {W{1'b0}};
              x_next_s     = rs;
              y_next_s     = rt;
              cnt_next_s   = CW'(W);
              busy_next_s  = 1'b1;
              state_next_s = ST_ITER;
            end
            default: begin
              out_next_s   = {W{1'b0}};
              done_next_s  = 1'b1;
              dbz_next_s   = 1'b0;
              ill_next_s   = 1'b1;
              state_next_s = ST_DONE;
            end
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_ITER: begin
        cnt_next_s = cnt_r - CW'(1);
        if (op_r == OP_MUL) begin
          acc_next_s = mul_acc_s;
          x_next_s   = {x_r[W-2:0], 1'b0};
          y_next_s   = {1'b0, y_r[W-1:1]};
        end else begin
          acc_next_s = div_rem_s;
          x_next_s   = div_quo_s;
        end
        if (cnt_r == CW'(1)) begin
          if (op_r == OP_MUL) begin
            out_next_s = mul_acc_s;
            dbz_next_s = 1'b0;
          end else if (y_r == {W{1'b0}}) begin
            out_next_s = {W{1'b1}};
            dbz_next_s = 1'b1;
          end else begin
            out_next_s = div_quo_s;
            dbz_next_s = 1'b0;
          end
          ill_next_s   = 1'b0;
          done_next_s  = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          busy_next_s = 1'b1;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any op in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      op_r    <= 3'b000;
      acc_r   <= {W{1'b0}};
      x_r     <= {W{1'b0}};
      y_r     <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      out_r   <= {W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      ill_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      op_r    <= op_next_s;
      acc_r   <= acc_next_s;
      x_r     <= x_next_s;
      y_r     <= y_next_s;
      cnt_r   <= cnt_next_s;
      out_r   <= out_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
      dbz_r   <= dbz_next_s;
      ill_r   <= ill_next_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign alu_out     = out_r;
  assign div_by_zero = dbz_r;
  assign illegal_op  = ill_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: signed and unsigned-CMP instances side by
// side, directed cases plus random ops against an arithmetic reference model.
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] rs, rt;
  logic       busy, done, div_by_zero, illegal_op;
  logic [7:0] alu_out;
  logic       busy_u, done_u, div_by_zero_u, illegal_op_u;
  logic [7:0] alu_out_u;

  int pass_cnt;
  int total_cnt;

  alu_seq #(.DATA_WIDTH(8), .SIGNED_CMP(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .alu_out(alu_out),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  alu_seq #(.DATA_WIDTH(8), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy_u), .done(done_u), .alu_out(alu_out_u),
    .div_by_zero(div_by_zero_u), .illegal_op(illegal_op_u)
  );

  always #5 clk = ~clk;

  function automatic int model(input int o, input int a, input int b, input bit sc);
    int sa, sb;
    case (o)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return (a * b) % 256;
      3: return (b == 0) ? 255 : (a / b);
      4: begin
        sa = (sc && a >= 128) ? a - 256 : a;
        sb = (sc && b >= 128) ? b - 256 : b;
        if (sa > sb) return 4;
        else if (sa == sb) return 2;
        else return 1;
      end
      default: return 0;
    endcase
  endfunction

  // lat = edges after the accepting edge at which done was seen (64 = timeout)
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [7:0] res, output logic [7:0] res_u,
                       output logic dz, output logic il, output logic bsy);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; rs = 8'($urandom); rt = 8'($urandom); op = 3'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    res = alu_out; res_u = alu_out_u; dz = div_by_zero; il = illegal_op; bsy = busy;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, alu_out, div_by_zero, illegal_op} !== 12'h000)
      $display("FAIL reset_state: got busy=%b done=%b out=%0d dbz=%b ill=%b, expected all 0",
               busy, done, alu_out, div_by_zero, illegal_op);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add_sub;
    int lat; logic [7:0] r, ru; logic dz, il, bs;
    issue(3'd0, 8'd200, 8'd100, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd44 || lat != 0) $display("FAIL add_wrap: got %0d lat %0d, expected 44 lat 0", r, lat);
    else pass_cnt++;
    issue(3'd1, 8'd5, 8'd9, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd252 || lat != 0) $display("FAIL sub_wrap: got %0d lat %0d, expected 252 lat 0", r, lat);
    else pass_cnt++;
  endtask

  task automatic test_mul;
    int n; bit busy_bad; int lat; logic [7:0] r, ru; logic dz, il, bs;
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs = 8'd13; rt = 8'd11;
    @(negedge clk);
    start = 1'b0;
    n = 0; busy_bad = 1'b0;
    while (done !== 1'b1 && n < 64) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (n == 2) begin
        start = 1'b1; op = 3'd0; rs = 8'd1; rt = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    total_cnt++;
    if (n != 8 || alu_out !== 8'd143 || busy !== 1'b0 || busy_bad)
      $display("FAIL mul_latency: got lat %0d out %0d busy %b busy_gap %b, expected lat 8 out 143 busy 0 busy_gap 0",
               n, alu_out, busy, busy_bad);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL mul_ignored_start: got done %b, expected 0", done);
    else pass_cnt++;
    issue(3'd2, 8'd255, 8'd255, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd1 || lat != 8) $display("FAIL mul_max: got %0d lat %0d, expected 1 lat 8", r, lat);
    else pass_cnt++;
  endtask

  task automatic test_div;
    int lat; logic [7:0] r, ru; logic dz, il, bs;
    issue(3'd3, 8'd200, 8'd7, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd28 || dz !== 1'b0 || lat != 8)
      $display("FAIL div_basic: got %0d dbz %b lat %0d, expected 28 dbz 0 lat 8", r, dz, lat);
    else pass_cnt++;
    issue(3'd3, 8'd5, 8'd0, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd255 || dz !== 1'b1 || lat != 8)
      $display("FAIL div_zero: got %0d dbz %b lat %0d, expected 255 dbz 1 lat 8", r, dz, lat);
    else pass_cnt++;
    issue(3'd0, 8'd1, 8'd2, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd3 || dz !== 1'b0)
      $display("FAIL div_zero_clear: got %0d dbz %b, expected 3 dbz 0", r, dz);
    else pass_cnt++;
  endtask

  task automatic test_cmp;
    int lat; logic [7:0] r, ru; logic dz, il, bs;
    issue(3'd4, 8'h80, 8'h01, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'h01) $display("FAIL cmp_signed: got %h, expected 01", r);
    else pass_cnt++;
    total_cnt++;
    if (ru !== 8'h04) $display("FAIL cmp_unsigned: got %h, expected 04", ru);
    else pass_cnt++;
    issue(3'd4, 8'h42, 8'h42, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'h02 || ru !== 8'h02 || lat != 0)
      $display("FAIL cmp_equal: got %h/%h lat %0d, expected 02/02 lat 0", r, ru, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat; logic [7:0] r, ru; logic dz, il, bs;
    issue(3'd3, 8'd250, 8'd3, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd83 || lat != 8) $display("FAIL b2b_div: got %0d lat %0d, expected 83 lat 8", r, lat);
    else pass_cnt++;
    start = 1'b1; op = 3'd0; rs = 8'd10; rt = 8'd20;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b1 || alu_out !== 8'd30)
      $display("FAIL b2b_add: got done %b out %0d, expected done 1 out 30", done, alu_out);
    else pass_cnt++;
    issue(3'd7, 8'd9, 8'd9, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd0 || il !== 1'b1 || lat != 0)
      $display("FAIL illegal_op: got out %0d ill %b lat %0d, expected 0 1 0", r, il, lat);
    else pass_cnt++;
    issue(3'd0, 8'd10, 8'd20, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd30 || il !== 1'b0)
      $display("FAIL illegal_clear: got out %0d ill %b, expected 30 0", r, il);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit saw_done; int lat; logic [7:0] r, ru; logic dz, il, bs;
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs = 8'd200; rt = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy: got busy %b, expected 1", busy);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_out !== 8'd0 || div_by_zero !== 1'b0)
      $display("FAIL reset_mid_async: got busy %b done %b out %0d dbz %b, expected 0 0 0 0",
               busy, done, alu_out, div_by_zero);
    else pass_cnt++;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done) $display("FAIL reset_mid_no_done: got a done pulse, expected none");
    else pass_cnt++;
    issue(3'd2, 8'd3, 8'd4, lat, r, ru, dz, il, bs);
    total_cnt++;
    if (r !== 8'd12 || lat != 8) $display("FAIL reset_mid_mul: got %0d lat %0d, expected 12 lat 8", r, lat);
    else pass_cnt++;
  endtask

  task automatic test_random;
    int lat, o, a, b, e, eu, elat; logic [7:0] r, ru; logic dz, il, bs;
    for (int i = 0; i < 40; i++) begin
      o = $urandom_range(0, 7);
      a = $urandom_range(0, 255);
      b = (i % 8 == 3) ? 0 : $urandom_range(0, 255);
      e = model(o, a, b, 1'b1);
      eu = model(o, a, b, 1'b0);
      elat = (o == 2 || o == 3) ? 8 : 0;
      issue(3'(o), 8'(a), 8'(b), lat, r, ru, dz, il, bs);
      total_cnt++;
      if (r !== 8'(e) || ru !== 8'(eu) || lat != elat || bs !== 1'b0 ||
          dz !== (o == 3 && b == 0) || il !== (o > 4))
        $display("FAIL random[%0d] op%0d %0d,%0d: got %0d/%0d lat %0d busy %b dbz %b ill %b, expected %0d/%0d lat %0d busy 0 dbz %b ill %b",
                 i, o, a, b, r, ru, lat, bs, dz, il, e, eu, elat, (o == 3 && b == 0), (o > 4));
      else pass_cnt++;
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; start = 1'b0; op = 3'd0; rs = 8'd0; rt = 8'd0;
    pass_cnt = 0; total_cnt = 0;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_cmp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
